// File: rtl/beacon_period_tracker.sv
// Beacon period tracker: timestamps det_i rising edges against the upstream
// ms count, measures wrap-aware intervals, window-checks them and tracks lock.
// Ports: clk, rst_n (async, active low), det_i, count_i[CW] -> interval_o[CW],
// interval_valid_o, in_window_o, locked_o, timeout_o
// (+ miss_count_o[8] with BEACON_PERIOD_TRACKER_STATS_EN).
module beacon_period_tracker #(
  parameter int MAX_COUNT    = 4095,
  parameter int PERIOD_MIN   = 700,
  parameter int PERIOD_MAX   = 1300,
  parameter int LOCK_CNT     = 3,
  parameter int MISS_TIMEOUT = 2000,
  localparam int CW          = $clog2(MAX_COUNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          det_i,
  input  logic [CW-1:0] count_i,
  output logic [CW-1:0] interval_o,
  output logic          interval_valid_o,
  output logic          in_window_o,
  output logic          locked_o,
  output logic          timeout_o
`ifdef BEACON_PERIOD_TRACKER_STATS_EN
  ,
  output logic [7:0]    miss_count_o
`endif
);

  if (!(PERIOD_MAX < MISS_TIMEOUT && MISS_TIMEOUT < MAX_COUNT &&
        LOCK_CNT >= 1 && LOCK_CNT <= 15)) begin : g_param_err
    $error("beacon_period_tracker: illegal parameter set");
  end

  localparam int            MOD_I = MAX_COUNT + 1;
  localparam logic [CW:0]   MOD   = MOD_I[CW:0];
  localparam logic [CW-1:0] P_MIN = PERIOD_MIN[CW-1:0];
  localparam logic [CW-1:0] P_MAX = PERIOD_MAX[CW-1:0];
  localparam logic [CW-1:0] T_OUT = MISS_TIMEOUT[CW-1:0];
  localparam logic [3:0]    L_CNT = LOCK_CNT[3:0];

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          det_q;
  logic [CW-1:0] last_ts_q, last_ts_d;
  logic [3:0]    good_cnt_q, good_cnt_d;
  logic [CW-1:0] interval_q, interval_d;
  logic          valid_q, valid_d;
  logic          in_win_q, in_win_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    miss_q, miss_d;

  logic          edge_w;
  logic [CW:0]   sub_w;
  logic [CW:0]   diff_full;
  logic [CW-1:0] diff;
  logic          win;
  logic          expired;
  logic          miss_evt;

  assign edge_w = det_i & ~det_q;
  assign sub_w  = {1'b0, count_i} - {1'b0, last_ts_q};
  // Borrow means the counter wrapped since the last timestamp.
  assign diff_full = sub_w[CW] ? sub_w + MOD : sub_w;
  assign diff      = diff_full[CW-1:0];
  assign win       = (diff >= P_MIN) && (diff <= P_MAX);
  assign expired   = diff > T_OUT;

  always_comb begin
    state_d    = state_q;
    last_ts_d  = last_ts_q;
    good_cnt_d = good_cnt_q;
    interval_d = interval_q;
    valid_d    = 1'b0;
    in_win_d   = in_win_q;
    timeout_d  = 1'b0;
    miss_evt   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (edge_w) begin
          last_ts_d  = count_i;
          good_cnt_d = 4'd0;
          state_d    = S_ARMED;
        end
      end
      S_ARMED, S_LOCKED: begin
        if (edge_w) begin
          interval_d = diff;
          valid_d    = 1'b1;
          last_ts_d  = count_i;
          in_win_d   = win;
          if (!win) begin
            good_cnt_d = 4'd0;
            state_d    = S_ARMED;
            miss_evt   = 1'b1;
          end else if (state_q == S_ARMED) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == L_CNT) state_d = S_LOCKED;
          end
        end else if (expired) begin
          timeout_d  = 1'b1;
          good_cnt_d = 4'd0;
          state_d    = S_IDLE;
          miss_evt   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    miss_d = (miss_evt && miss_q != 8'hFF) ? miss_q + 8'd1 : miss_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      det_q      <= 1'b0;
      last_ts_q  <= '0;
      good_cnt_q <= '0;
      interval_q <= '0;
      valid_q    <= 1'b0;
      in_win_q   <= 1'b0;
      timeout_q  <= 1'b0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      det_q      <= det_i;
      last_ts_q  <= last_ts_d;
      good_cnt_q <= good_cnt_d;
      interval_q <= interval_d;
      valid_q    <= valid_d;
      in_win_q   <= in_win_d;
      timeout_q  <= timeout_d;
      miss_q     <= miss_d;
    end
  end

  assign interval_o       = interval_q;
  assign interval_valid_o = valid_q;
  assign in_window_o      = in_win_q;
  assign locked_o         = (state_q == S_LOCKED);
  assign timeout_o        = timeout_q;

`ifdef BEACON_PERIOD_TRACKER_STATS_EN
  assign miss_count_o = miss_q;
`else
  logic unused_miss;
  assign unused_miss = ^miss_q;
`endif

endmodule

// File: doc/beacon_period_tracker.md
Name: beacon_period_tracker

Overview:
- Sits directly downstream of the millisecond counter and consumes its free-running count.
- Timestamps rising edges of the beacon detect strobe and computes the interval between consecutive edges in ms, with wrap-aware subtraction.
- Checks each interval against a period window and declares lock after consecutive good intervals.
- Drops lock and re-arms when detect edges stop arriving.

Parameters:
- MAX_COUNT, 4095: terminal value of the upstream ms counter. The count runs 0..MAX_COUNT, so the modulus is MAX_COUNT+1. CW = $clog2(MAX_COUNT).
- PERIOD_MIN, 700: smallest in-window interval in ms (inclusive).
- PERIOD_MAX, 1300: largest in-window interval in ms (inclusive).
- LOCK_CNT, 3: consecutive in-window intervals required for lock (1..15).
- MISS_TIMEOUT, 2000: ms without an edge before the block returns to IDLE.
- Required ordering: PERIOD_MAX < MISS_TIMEOUT < MAX_COUNT. Elaboration fails otherwise.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- det_i  in  1  beacon detect level, synchronous to clk
- count_i  in  CW  ms count from upstream counter
- interval_o  out  CW  last measured interval, ms
- interval_valid_o  out  1  one-cycle pulse when interval_o updates
- in_window_o  out  1  last interval within [PERIOD_MIN, PERIOD_MAX]
- locked_o  out  1  tracker in LOCKED state
- timeout_o  out  1  one-cycle pulse on MISS_TIMEOUT expiry

Behaviour:
- Reset (rst_n low, async): state=IDLE, det_q=0, last_ts=0, good_cnt=0. All outputs are 0.
- Edge detect: edge = det_i & ~det_q, with det_q registered every cycle. An edge is evaluated in the cycle det_i is first sampled high. All outputs are registered, so a response appears on the following clock.
- Arithmetic: diff = (count_i - last_ts) mod (MAX_COUNT+1), computed at CW+1 bits with conditional add of MAX_COUNT+1 on borrow. Wrap case: last_ts=4000, count_i=904 -> diff=1000.
- elapsed uses the same formula and is evaluated every cycle in ARMED and LOCKED.
- State IDLE:
  - edge -> last_ts<=count_i, good_cnt<=0, go to ARMED.
  - No interval_valid_o pulse.
- State ARMED:
  - edge -> interval_o<=diff and interval_valid_o pulse; last_ts<=count_i.
  - If diff in window: in_window_o<=1, good_cnt++. If good_cnt+1==LOCK_CNT, go to LOCKED.
  - If diff out of window: in_window_o<=0, good_cnt<=0, stay in ARMED.
  - No edge and elapsed > MISS_TIMEOUT: timeout_o pulse, good_cnt<=0, go to IDLE.
- State LOCKED:
  - edge in window: update interval_o, pulse valid, stay in LOCKED.
  - edge out of window: update interval_o, pulse valid, in_window_o<=0, good_cnt<=0, go to ARMED.
  - elapsed > MISS_TIMEOUT: timeout_o pulse, go to IDLE.
- locked_o is 1 exactly while the state is LOCKED.
- Boundaries:
  - diff==0 (two edges in same ms) is out of window.
  - PERIOD_MIN and PERIOD_MAX are both in window.
  - elapsed==MISS_TIMEOUT does not time out. MISS_TIMEOUT+1 does.
  - Edge and timeout condition in the same cycle: the edge wins and is processed normally. Such a diff is always > PERIOD_MAX, so the next state is ARMED and timeout_o stays 0.
  - det_i held high counts as one edge only.
  - In IDLE, timeout is never evaluated.
  - in_window_o and interval_o hold their values until the next edge. A timeout does not clear them.
  - rst_n asserted mid-interval discards last_ts and good_cnt. The first edge after release only arms.

Optional Feature:
- Macro: BEACON_PERIOD_TRACKER_STATS_EN.
- When defined, adds port miss_count_o  out  8.
- miss_count_o is a saturating count, held at 255, of:
  - out-of-window edges in ARMED or LOCKED;
  - timeouts.
- It is cleared only by rst_n and updates on the same cycle as interval_valid_o / timeout_o.
- When undefined, the port and its counter are absent and behaviour is otherwise identical.

Test Plan:
1. Reset, then det_i edges at count_i=100, 1100, 2100, 3100 -> interval_o=1000 with valid pulse on the 2nd, 3rd and 4th edges; locked_o=1 the cycle after the 4th edge.
2. Wrap: lock established, next edge at last_ts=3900 and count_i=804 -> interval_o=1000, in_window_o=1, locked_o stays 1.
3. While locked, edge with diff=500 -> in_window_o=0, locked_o=0, state ARMED. Next edge diff=1000 -> good_cnt=1, locked_o=0. With STATS_EN: miss_count_o=1.
4. Timeout: armed at count_i=0, no edge. At count_i=2000 -> no timeout_o. At count_i=2001 -> one timeout_o pulse, locked_o=0. Next edge produces no valid pulse.
5. Boundaries: intervals of 700, 1300, 699, 1301 and 0 -> in_window_o = 1, 1, 0, 0, 0 respectively.
6. Reset mid-operation: locked, rst_n pulsed low asynchronously between clocks -> all outputs 0 immediately. The first subsequent edge gives no valid pulse. det_i held high for 5000 cycles gives exactly one edge.
